id_stage: RTL and testbench

- Instruction-decode pipeline stage of the 5-stage MIPS core.
- Sits between the IF/ID latch and EX; drives the register file read addresses and captures the decoded control into the ID/EX register.
- The register file reads synchronously (registered dout, write-through bypass), so rf data arriving at EX aligns with this block's registered ex_* outputs.
- Owns load-use hazard detection (bubble insertion) and EX-backpressure hold.

---
 rtl/mips_pkg.sv | 60 ++++++
 rtl/id_decoder.sv | 109 ++++++++++
 rtl/id_stage.sv | 177 +++++++++++++++++
 tb/tb_id_stage.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcode/funct constants, ALU-op and branch encodings, ID FSM states
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_SRA = 4'd9,
    ALU_LUI = 4'd10
  } alu_op_t;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_J    = 3'd3,
    BR_JAL  = 3'd4,
    BR_JR   = 3'd5
  } br_type_t;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } id_state_t;

endpackage

// File: rtl/id_decoder.sv
// rtl/id_decoder.sv - combinational MIPS instruction decoder
// ILLEGAL_TRAP_EN exposes the illegal flag as a port.
module id_decoder
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] instr,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] imm,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        dest,
  output logic              alu_src_imm,
  output logic              reg_wr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [2:0]        br_type,
  output logic              uses_rt
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic              illegal
`endif
);

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [15:0]       imm16;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;
  logic [DATA_W-1:0] imm_lui;
  logic [DATA_W-1:0] imm_shamt;
  logic              wr;
  logic              bad;

  assign opcode    = instr[31:26];
  assign funct     = instr[5:0];
  assign rs        = instr[25:21];
  assign rt        = instr[20:16];
  assign imm16     = instr[15:0];
  assign imm_sext  = {{(DATA_W-16){imm16[15]}}, imm16};
  assign imm_zext  = {{(DATA_W-16){1'b0}}, imm16};
  assign imm_lui   = {imm16, {(DATA_W-16){1'b0}}};
  assign imm_shamt = {{(DATA_W-5){1'b0}}, instr[10:6]};

  always_comb begin
    alu_op      = ALU_ADD;
    imm         = imm_sext;
    dest        = 5'd0;
    alu_src_imm = 1'b0;
    wr          = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    br_type     = BR_NONE;
    uses_rt     = 1'b0;
    bad         = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        uses_rt = 1'b1;
        dest    = instr[15:11];
        wr      = 1'b1;
        case (funct)
          FN_ADDU: alu_op = ALU_ADD;
          FN_SUBU: alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLL:  begin alu_op = ALU_SLL; imm = imm_shamt; alu_src_imm = 1'b1; end
          FN_SRL:  begin alu_op = ALU_SRL; imm = imm_shamt; alu_src_imm = 1'b1; end
          FN_SRA:  begin alu_op = ALU_SRA; imm = imm_shamt; alu_src_imm = 1'b1; end
          FN_JR:   begin wr = 1'b0; dest = 5'd0; br_type = BR_JR; end
          default: bad = 1'b1;
        endcase
      end
      OP_ADDIU: begin dest = rt; wr = 1'b1; alu_src_imm = 1'b1; end
      OP_SLTI:  begin dest = rt; wr = 1'b1; alu_src_imm = 1'b1; alu_op = ALU_SLT; end
      OP_ANDI:  begin dest = rt; wr = 1'b1; alu_src_imm = 1'b1; alu_op = ALU_AND; imm = imm_zext; end
      OP_ORI:   begin dest = rt; wr = 1'b1; alu_src_imm = 1'b1; alu_op = ALU_OR;  imm = imm_zext; end
      OP_XORI:  begin dest = rt; wr = 1'b1; alu_src_imm = 1'b1; alu_op = ALU_XOR; imm = imm_zext; end
      OP_LUI:   begin dest = rt; wr = 1'b1; alu_src_imm = 1'b1; alu_op = ALU_LUI; imm = imm_lui; end
      OP_LW:    begin dest = rt; wr = 1'b1; alu_src_imm = 1'b1; mem_rd = 1'b1; end
      OP_SW:    begin uses_rt = 1'b1; alu_src_imm = 1'b1; mem_wr = 1'b1; end
      OP_BEQ:   begin uses_rt = 1'b1; alu_op = ALU_SUB; br_type = BR_BEQ; end
      OP_BNE:   begin uses_rt = 1'b1; alu_op = ALU_SUB; br_type = BR_BNE; end
      OP_J:     br_type = BR_J;
      OP_JAL:   begin dest = REG_RA; wr = 1'b1; br_type = BR_JAL; end
      default:  bad = 1'b1;
    endcase
    // Undecodable words leave the pipe as side-effect-free NOPs.
    if (bad) begin
      alu_op      = ALU_ADD;
      dest        = 5'd0;
      alu_src_imm = 1'b0;
      wr          = 1'b0;
      mem_rd      = 1'b0;
      mem_wr      = 1'b0;
      br_type     = BR_NONE;
      uses_rt     = 1'b0;
    end
    reg_wr = wr & (dest != 5'd0);
  end

`ifdef ILLEGAL_TRAP_EN
  assign illegal = bad;
`endif

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - MIPS ID stage: decode, load-use bubbles, EX backpressure hold, ID/EX register
// ILLEGAL_TRAP_EN adds the ex_illegal output.
module id_stage
  import mips_pkg::*;
#(
  parameter int LU_BUBBLES = 1,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [DATA_W-1:0] if_instr,
  input  logic [DATA_W-1:0] if_pc,
  output logic              id_ready,
  input  logic              flush,
  input  logic              ex_ready,
  output logic [4:0]        rf_r1_addr,
  output logic [4:0]        rf_r2_addr,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [3:0]        ex_alu_op,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [DATA_W-1:0] ex_imm,
  output logic              ex_alu_src_imm,
  output logic              ex_reg_wr,
  output logic              ex_mem_rd,
  output logic              ex_mem_wr,
  output logic [2:0]        ex_br_type,
  output logic [25:0]       ex_jtarget
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic              ex_illegal
`endif
);

  localparam int CNT_W = 2;

  logic [3:0]        dec_alu_op;
  logic [DATA_W-1:0] dec_imm;
  logic [4:0]        dec_rs;
  logic [4:0]        dec_rt;
  logic [4:0]        dec_dest;
  logic              dec_alu_src_imm;
  logic              dec_reg_wr;
  logic              dec_mem_rd;
  logic              dec_mem_wr;
  logic [2:0]        dec_br_type;
  logic              dec_uses_rt;
`ifdef ILLEGAL_TRAP_EN
  logic              dec_illegal;
`endif

  id_state_t         state;
  id_state_t         state_d;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_d;
  logic              advance;
  logic              hazard;
  logic              load;
  logic              kill;

  id_decoder #(.DATA_W(DATA_W)) u_dec (
    .instr       (if_instr),
    .alu_op      (dec_alu_op),
    .imm         (dec_imm),
    .rs          (dec_rs),
    .rt          (dec_rt),
    .dest        (dec_dest),
    .alu_src_imm (dec_alu_src_imm),
    .reg_wr      (dec_reg_wr),
    .mem_rd      (dec_mem_rd),
    .mem_wr      (dec_mem_wr),
    .br_type     (dec_br_type),
    .uses_rt     (dec_uses_rt)
`ifdef ILLEGAL_TRAP_EN
    ,
    .illegal     (dec_illegal)
`endif
  );

  assign advance = ~ex_valid | ex_ready;
  assign hazard  = if_valid & ex_valid & ex_mem_rd & (ex_rd != 5'd0) &
                   ((ex_rd == dec_rs) | ((ex_rd == dec_rt) & dec_uses_rt));
  assign id_ready = rst_n & advance & ~hazard & (state == RUN) & ~flush;

  // A held entry must see its own operands again from the synchronous regfile.
  assign rf_r1_addr = advance ? dec_rs : ex_rs;
  assign rf_r2_addr = advance ? dec_rt : ex_rt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    load    = 1'b0;
    kill    = 1'b0;
    if (flush) begin
      kill    = 1'b1;
      state_d = RUN;
      cnt_d   = '0;
    end else begin
      case (state)
        RUN: begin
          if (!advance) begin
            load = 1'b0;
          end else if (hazard) begin
            kill  = 1'b1;
            cnt_d = CNT_W'(LU_BUBBLES - 1);
            if (LU_BUBBLES > 1) state_d = BUBBLE;
          end else begin
            load = 1'b1;
          end
        end
        BUBBLE: begin
          kill  = 1'b1;
          cnt_d = cnt - 1'b1;
          if (cnt == CNT_W'(1)) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid       <= 1'b0;
      ex_pc          <= '0;
      ex_alu_op      <= '0;
      ex_rs          <= '0;
      ex_rt          <= '0;
      ex_rd          <= '0;
      ex_imm         <= '0;
      ex_alu_src_imm <= 1'b0;
      ex_reg_wr      <= 1'b0;
      ex_mem_rd      <= 1'b0;
      ex_mem_wr      <= 1'b0;
      ex_br_type     <= '0;
      ex_jtarget     <= '0;
`ifdef ILLEGAL_TRAP_EN
      ex_illegal     <= 1'b0;
`endif
    end else if (kill) begin
      ex_valid       <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      ex_illegal     <= 1'b0;
`endif
    end else if (load) begin
      ex_valid       <= if_valid;
      ex_pc          <= if_pc;
      ex_alu_op      <= dec_alu_op;
      ex_rs          <= dec_rs;
      ex_rt          <= dec_rt;
      ex_rd          <= dec_dest;
      ex_imm         <= dec_imm;
      ex_alu_src_imm <= dec_alu_src_imm;
      ex_reg_wr      <= dec_reg_wr;
      ex_mem_rd      <= dec_mem_rd;
      ex_mem_wr      <= dec_mem_wr;
      ex_br_type     <= dec_br_type;
      ex_jtarget     <= if_instr[25:0];
`ifdef ILLEGAL_TRAP_EN
      ex_illegal     <= if_valid & dec_illegal;
`endif
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed self-checking bench for id_stage (LU_BUBBLES 1 and 2)
// Honours ILLEGAL_TRAP_EN when defined.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush;
  logic        ex_ready;

  logic        id_ready, ex_valid, ex_alu_src_imm, ex_reg_wr, ex_mem_rd, ex_mem_wr;
  logic [4:0]  rf_r1_addr, rf_r2_addr, ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_pc, ex_imm;
  logic [3:0]  ex_alu_op;
  logic [2:0]  ex_br_type;
  logic [25:0] ex_jtarget;

  logic        b_id_ready, b_ex_valid, b_ex_alu_src_imm, b_ex_reg_wr, b_ex_mem_rd, b_ex_mem_wr;
  logic [4:0]  b_rf_r1_addr, b_rf_r2_addr, b_ex_rs, b_ex_rt, b_ex_rd;
  logic [31:0] b_ex_pc, b_ex_imm;
  logic [3:0]  b_ex_alu_op;
  logic [2:0]  b_ex_br_type;
  logic [25:0] b_ex_jtarget;
`ifdef ILLEGAL_TRAP_EN
  logic        ex_illegal, b_ex_illegal;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  id_stage #(.LU_BUBBLES(1), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready),
    .rf_r1_addr(rf_r1_addr), .rf_r2_addr(rf_r2_addr), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_alu_op(ex_alu_op), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_imm(ex_imm),
    .ex_alu_src_imm(ex_alu_src_imm), .ex_reg_wr(ex_reg_wr), .ex_mem_rd(ex_mem_rd),
    .ex_mem_wr(ex_mem_wr), .ex_br_type(ex_br_type), .ex_jtarget(ex_jtarget)
`ifdef ILLEGAL_TRAP_EN
    , .ex_illegal(ex_illegal)
`endif
  );

  id_stage #(.LU_BUBBLES(2), .DATA_W(32)) dut_b2 (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(b_id_ready), .flush(flush), .ex_ready(ex_ready),
    .rf_r1_addr(b_rf_r1_addr), .rf_r2_addr(b_rf_r2_addr), .ex_valid(b_ex_valid), .ex_pc(b_ex_pc),
    .ex_alu_op(b_ex_alu_op), .ex_rs(b_ex_rs), .ex_rt(b_ex_rt), .ex_rd(b_ex_rd), .ex_imm(b_ex_imm),
    .ex_alu_src_imm(b_ex_alu_src_imm), .ex_reg_wr(b_ex_reg_wr), .ex_mem_rd(b_ex_mem_rd),
    .ex_mem_wr(b_ex_mem_wr), .ex_br_type(b_ex_br_type), .ex_jtarget(b_ex_jtarget)
`ifdef ILLEGAL_TRAP_EN
    , .ex_illegal(b_ex_illegal)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  alu;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        wr;
    logic        src;
    logic [2:0]  br;
    logic        mw;
  } vec_t;

  vec_t tbl[9];

  localparam logic [31:0] I_ADDIU = 32'h24080005;
  localparam logic [31:0] I_LW    = 32'h8D090000;
  localparam logic [31:0] I_ADDU  = 32'h01285021;

  initial begin
    // instr, alu_op, imm, rd, reg_wr, alu_src_imm, br_type, mem_wr
    tbl[0] = '{32'h3C081234, 4'd10, 32'h12340000, 5'd8,  1'b1, 1'b1, 3'd0, 1'b0}; // LUI
    tbl[1] = '{32'h31098000, 4'd2,  32'h00008000, 5'd9,  1'b1, 1'b1, 3'd0, 1'b0}; // ANDI zext
    tbl[2] = '{32'h2509FFFF, 4'd0,  32'hFFFFFFFF, 5'd9,  1'b1, 1'b1, 3'd0, 1'b0}; // ADDIU -1
    tbl[3] = '{32'hAD090004, 4'd0,  32'h00000004, 5'd0,  1'b0, 1'b1, 3'd0, 1'b1}; // SW
    tbl[4] = '{32'h1509FFFF, 4'd1,  32'hFFFFFFFF, 5'd0,  1'b0, 1'b0, 3'd2, 1'b0}; // BNE
    tbl[5] = '{32'h0C000040, 4'd0,  32'h00000040, 5'd31, 1'b1, 1'b0, 3'd4, 1'b0}; // JAL
    tbl[6] = '{32'h000950C3, 4'd9,  32'h00000003, 5'd10, 1'b1, 1'b1, 3'd0, 1'b0}; // SRA 3
    tbl[7] = '{32'h01280021, 4'd0,  32'h00000021, 5'd0,  1'b0, 1'b0, 3'd0, 1'b0}; // ADDU to $0
    tbl[8] = '{32'h03E00008, 4'd0,  32'h00000008, 5'd0,  1'b0, 1'b0, 3'd5, 1'b0}; // JR $ra

    rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0; ex_ready = 1'b1;
    #3;
    check("rst_id_ready_low", {31'd0, id_ready}, 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    #1;
    check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_ex_pc", ex_pc, 32'd0);
    check("rst_ex_imm", ex_imm, 32'd0);
    check("rst_ex_rd", {27'd0, ex_rd}, 32'd0);
    check("rst_ex_reg_wr", {31'd0, ex_reg_wr}, 32'd0);
    check("rst_ex_alu_op", {28'd0, ex_alu_op}, 32'd0);
    check("rst_id_ready", {31'd0, id_ready}, 32'd1);

    // ADDIU $8,$0,5
    if_valid = 1'b1; if_instr = I_ADDIU; if_pc = 32'h100;
    #1;
    check("addiu_id_ready", {31'd0, id_ready}, 32'd1);
    check("addiu_rf_r2", {27'd0, rf_r2_addr}, 32'd8);
    cyc();
    if_valid = 1'b0;
    #1;
    check("addiu_ex_valid", {31'd0, ex_valid}, 32'd1);
    check("addiu_ex_rd", {27'd0, ex_rd}, 32'd8);
    check("addiu_ex_imm", ex_imm, 32'd5);
    check("addiu_src_imm", {31'd0, ex_alu_src_imm}, 32'd1);
    check("addiu_reg_wr", {31'd0, ex_reg_wr}, 32'd1);
    check("addiu_ex_pc", ex_pc, 32'h100);

    // Load-use with one bubble
    if_valid = 1'b1; if_instr = I_LW; if_pc = 32'h104;
    cyc();
    if_instr = I_ADDU; if_pc = 32'h108;
    #1;
    check("lu1_lw_mem_rd", {31'd0, ex_mem_rd}, 32'd1);
    check("lu1_hazard_ready", {31'd0, id_ready}, 32'd0);
    cyc();
    #1;
    check("lu1_bubble_valid", {31'd0, ex_valid}, 32'd0);
    check("lu1_bubble_ready", {31'd0, id_ready}, 32'd1);
    cyc();
    if_instr = I_ADDIU; if_pc = 32'h10C;
    #1;
    check("lu1_addu_valid", {31'd0, ex_valid}, 32'd1);
    check("lu1_addu_rs", {27'd0, ex_rs}, 32'd9);
    check("lu1_addu_rt", {27'd0, ex_rt}, 32'd8);
    check("lu1_addu_rd", {27'd0, ex_rd}, 32'd10);
    check("lu1_addu_pc", ex_pc, 32'h108);

    // EX backpressure: ADDU held, ADDIU waiting
    ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp%0d_id_ready", i), {31'd0, id_ready}, 32'd0);
      check($sformatf("bp%0d_rf_r1", i), {27'd0, rf_r1_addr}, 32'd9);
      check($sformatf("bp%0d_rf_r2", i), {27'd0, rf_r2_addr}, 32'd8);
      check($sformatf("bp%0d_ex_rd", i), {27'd0, ex_rd}, 32'd10);
      check($sformatf("bp%0d_ex_valid", i), {31'd0, ex_valid}, 32'd1);
      cyc();
    end
    // flush wins over hold
    flush = 1'b1;
    #1;
    check("fl_hold_id_ready", {31'd0, id_ready}, 32'd0);
    cyc();
    flush = 1'b0; ex_ready = 1'b1;
    #1;
    check("fl_hold_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("fl_hold_id_ready_back", {31'd0, id_ready}, 32'd1);
    check("fl_hold_rf_r1", {27'd0, rf_r1_addr}, 32'd0);
    cyc();
    #1;
    check("post_fl_ex_rd", {27'd0, ex_rd}, 32'd8);
    check("post_fl_ex_pc", ex_pc, 32'h10C);

    // Illegal opcode
    if_instr = 32'hFC000000; if_pc = 32'h110;
    cyc();
    if_valid = 1'b0;
    #1;
    check("ill_ex_valid", {31'd0, ex_valid}, 32'd1);
    check("ill_reg_wr", {31'd0, ex_reg_wr}, 32'd0);
    check("ill_mem", {30'd0, ex_mem_rd, ex_mem_wr}, 32'd0);
    check("ill_br", {29'd0, ex_br_type}, 32'd0);
`ifdef ILLEGAL_TRAP_EN
    check("ill_flag", {31'd0, ex_illegal}, 32'd1);
`endif

    // Decode table
    for (int i = 0; i < 9; i++) begin
      if_valid = 1'b1; if_instr = tbl[i].instr; if_pc = 32'h200 + 32'(4 * i);
      cyc();
      if_valid = 1'b0;
      #1;
      check($sformatf("tbl%0d_alu", i), {28'd0, ex_alu_op}, {28'd0, tbl[i].alu});
      check($sformatf("tbl%0d_imm", i), ex_imm, tbl[i].imm);
      check($sformatf("tbl%0d_rd", i), {27'd0, ex_rd}, {27'd0, tbl[i].rd});
      check($sformatf("tbl%0d_wr", i), {31'd0, ex_reg_wr}, {31'd0, tbl[i].wr});
      check($sformatf("tbl%0d_src", i), {31'd0, ex_alu_src_imm}, {31'd0, tbl[i].src});
      check($sformatf("tbl%0d_br", i), {29'd0, ex_br_type}, {29'd0, tbl[i].br});
      check($sformatf("tbl%0d_mw", i), {31'd0, ex_mem_wr}, {31'd0, tbl[i].mw});
      check($sformatf("tbl%0d_jt", i), {6'd0, ex_jtarget}, {6'd0, tbl[i].instr[25:0]});
    end

    // LU_BUBBLES=2 instance
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    if_valid = 1'b1; if_instr = I_LW; if_pc = 32'h300;
    cyc();
    if_instr = I_ADDU; if_pc = 32'h304;
    #1;
    check("lu2_hazard_ready", {31'd0, b_id_ready}, 32'd0);
    cyc();
    #1;
    check("lu2_b1_valid", {31'd0, b_ex_valid}, 32'd0);
    check("lu2_b1_ready", {31'd0, b_id_ready}, 32'd0);
    cyc();
    #1;
    check("lu2_b2_valid", {31'd0, b_ex_valid}, 32'd0);
    check("lu2_b2_ready", {31'd0, b_id_ready}, 32'd1);
    cyc();
    #1;
    check("lu2_addu_valid", {31'd0, b_ex_valid}, 32'd1);
    check("lu2_addu_rd", {27'd0, b_ex_rd}, 32'd10);

    // flush during BUBBLE while EX stalls
    if_instr = I_LW; if_pc = 32'h308;
    cyc();
    if_instr = I_ADDU; if_pc = 32'h30C;
    cyc();
    ex_ready = 1'b0; flush = 1'b1;
    #1;
    check("flb_ready_during", {31'd0, b_id_ready}, 32'd0);
    check("flb_valid_during", {31'd0, b_ex_valid}, 32'd0);
    cyc();
    flush = 1'b0; ex_ready = 1'b1;
    #1;
    check("flb_valid_after", {31'd0, b_ex_valid}, 32'd0);
    check("flb_ready_after", {31'd0, b_id_ready}, 32'd1);
    cyc();
    #1;
    check("flb_addu_valid", {31'd0, b_ex_valid}, 32'd1);
    check("flb_addu_pc", b_ex_pc, 32'h30C);

    // async reset while a load is stalled in ID/EX
    if_instr = I_LW; if_pc = 32'h310;
    cyc();
    if_instr = I_ADDU; ex_ready = 1'b0;
    #1;
    check("ar_pre_valid", {31'd0, b_ex_valid}, 32'd1);
    check("ar_pre_mem_rd", {31'd0, b_ex_mem_rd}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("ar_valid", {31'd0, b_ex_valid}, 32'd0);
    check("ar_mem_rd", {31'd0, b_ex_mem_rd}, 32'd0);
    check("ar_pc", b_ex_pc, 32'd0);
    check("ar_b_id_ready", {31'd0, b_id_ready}, 32'd0);
    check("ar_id_ready", {31'd0, id_ready}, 32'd0);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
